serial_subtractor: RTL and testbench

- Bit-serial subtractor; computes res = x - y - bin over WIDTH clock cycles, LSB first, with one borrow flip-flop.
- Reuses the single-bit cell structure of the team's full-adder primitives, run in the subtract direction: difference bit plus borrow, not sum plus carry.
- Sits in area-constrained datapaths that accept multi-cycle latency in exchange for one-bit arithmetic.
- Valid/ready handshakes on input and output.

---
 rtl/serial_subtractor_if.sv | 37 +++
 rtl/serial_subtractor.sv | 154 +++++++++++++++
 tb/tb_serial_subtractor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
// Optional overflow output is present when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             bout;
  logic             busy;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  // Operand producer / result consumer side
  modport master (
    output in_valid, x, y, bin, out_ready,
    input  in_ready, out_valid, res, bout, busy
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  // Subtractor side
  modport slave (
    input  in_valid, x, y, bin, out_ready,
    output in_ready, out_valid, res, bout, busy
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: res = x - y - bin, one bit per cycle, LSB first.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a registered two's-complement
// overflow flag (ovf) on the interface.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned SW = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_sh_q, x_sh_d;
  logic [WIDTH-1:0] y_sh_q, y_sh_d;
  logic [SW-1:0]    res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             diff_bit;
  logic             borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
  logic             x_msb_q, x_msb_d;
  logic             y_msb_q, y_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_sh_q      <= '0;
      y_sh_q      <= '0;
      res_sh_q    <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      x_msb_q     <= 1'b0;
      y_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_sh_q      <= x_sh_d;
      y_sh_q      <= y_sh_d;
      res_sh_q    <= res_sh_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      bout_q      <= bout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
      x_msb_q     <= x_msb_d;
      y_msb_q     <= y_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Next-state, one-bit subtract cell and output decode
  always_comb begin
    state_d    = state_q;
    x_sh_d     = x_sh_q;
    y_sh_d     = y_sh_q;
    res_sh_d   = res_sh_q;
    borrow_d   = borrow_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    bout_d     = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    x_msb_d    = x_msb_q;
    y_msb_d    = y_msb_q;
    ovf_d      = ovf_q;
`endif

    // Full-subtractor cell on the current LSBs and stored borrow
    diff_bit   = x_sh_q[0] ^ y_sh_q[0] ^ borrow_q;
    borrow_nxt = (~x_sh_q[0] & y_sh_q[0]) | (~(x_sh_q[0] ^ y_sh_q[0]) & borrow_q);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_sh_d   = bus.x;
          y_sh_d   = bus.y;
          borrow_d = bus.bin;
          cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
          x_msb_d  = bus.x[WIDTH-1];
          y_msb_d  = bus.y[WIDTH-1];
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        x_sh_d   = x_sh_q >> 1;
        y_sh_d   = y_sh_q >> 1;
        res_sh_d = SW'({diff_bit, res_sh_q} >> 1);
        borrow_d = borrow_nxt;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: publish the full difference and the final borrow
          res_d   = {diff_bit, res_sh_q};
          bout_d  = borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (x_msb_q != y_msb_q) && (diff_bit != x_msb_q);
`endif
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.res       = res_q;
  assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed cases plus
// random operands against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cmp_cnt;
  int   err_cnt;
  int   cyc;
  int   accept_cyc;
  logic prev_valid;
  exp_t exp_q[$];

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
    exp_t e;
    int   u;
    int   s;
    u = int'(xv) - int'(yv) - int'(bv);
    s = int'($signed(xv)) - int'($signed(yv)) - int'(bv);
    e.res  = W'(u);
    e.bout = (u < 0);
    e.ovf  = (s < -128) || (s > 127);
    return e;
  endfunction

  // Accept watcher: a handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.x, bus.y, bus.bin));
      accept_cyc = cyc + 1;
    end
  end

  always @(negedge rst_n) exp_q.delete();

  // Output monitor: latency, exclusivity and result checks
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.out_valid && !prev_valid)
        chk("latency", 32'(cyc - accept_cyc), 32'(W));
      if (bus.out_valid) begin
        chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        chk("busy_in_done", 32'(bus.busy), 32'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_result: got res=%0h with empty scoreboard", bus.res);
        end else begin
          e = exp_q.pop_front();
          chk("res", 32'(bus.res), 32'(e.res));
          chk("bout", 32'(bus.bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
        end
      end
      prev_valid = bus.out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
    int n;
    n = 0;
    bus.x = xv;
    bus.y = yv;
    bus.bin = bv;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (n >= 200) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 400) begin
      @(posedge clk);
      #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 400) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout: pending=%0d busy=%0b", exp_q.size(), bus.busy);
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int n;
    cmp_cnt = 0;
    err_cnt = 0;
    cyc = 0;
    accept_cyc = 0;
    prev_valid = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Basic op with busy-duration count
    send(8'h05, 8'h03, 1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    chk("busy_cycles", 32'(n), 32'd9);
    drain(1'b0);

    send(8'h03, 8'h05, 1'b0); drain(1'b0);
    send(8'h00, 8'h00, 1'b1); drain(1'b0);
    send(8'hA5, 8'hA5, 1'b0); drain(1'b0);

    // Backpressure with new operands pending during DONE
    bus.out_ready = 1'b0;
    send(8'h10, 8'h01, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", 32'(bus.out_valid), 32'd1);
    bus.x = 8'hFF;
    bus.y = 8'h00;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_res_stable", 32'(bus.res), 32'h0F);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_after_release", 32'(bus.in_ready), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 20);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain(1'b0);

    // Reset in the fourth RUN cycle aborts the operation
    send(8'h80, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_res", 32'(bus.res), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h09, 8'h04, 1'b0); drain(1'b0);

    // Operand and control corruption during RUN has no effect
    send(8'h3C, 8'h0F, 1'b0);
    repeat (8) begin
      bus.x = ~bus.x;
      bus.y = ~bus.y;
      bus.bin = ~bus.bin;
      bus.in_valid = ~bus.in_valid;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain(1'b0);

    // Signed overflow corner cases
    send(8'h80, 8'h01, 1'b0); drain(1'b0);
    send(8'h7F, 8'hFF, 1'b0); drain(1'b0);
    send(8'h05, 8'h03, 1'b0); drain(1'b0);

    // Random operands with random consumer backpressure
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
